// File: rtl/sdram_pkg.sv
// Shared types and default sizing for the SDRAM burst scheduler.
package sdram_pkg;

   localparam int BURST_LEN_DEF   = 256;
   localparam int FRAME_WORDS_DEF = 307200;
   localparam int ADDR_W_DEF      = 24;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_DATA,
      RD_REQ,
      RD_DATA
   } sched_state_e;

endpackage

// File: rtl/frame_addr_cnt.sv
// Linear frame offset counter for one side (write or read) of the frame buffer.
// Advances by one burst at each completed burst and wraps at the end of a frame.
// A frame-sync rising edge clears the offset immediately when the side is not
// busy; otherwise the clear is held pending and replaces the next advance.
// Optional bank bit is present when SDRAM_PING_PONG_EN is defined.
module frame_addr_cnt
   import sdram_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int BURST_LEN   = BURST_LEN_DEF,
   parameter int FRAME_WORDS = FRAME_WORDS_DEF
`ifdef SDRAM_PING_PONG_EN
   ,
   parameter bit BANK_LOAD   = 1'b0
`endif
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_busy,
   input  logic              i_advance,
   input  logic              i_sync_rise,
`ifdef SDRAM_PING_PONG_EN
   input  logic              i_bank_load,
   output logic              o_bank_nxt,
`endif
   output logic [ADDR_W-1:0] o_offset_nxt,
   output logic              o_wrap
);

   localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(BURST_LEN);
   localparam logic [ADDR_W-1:0] FRAME = ADDR_W'(FRAME_WORDS);

   logic [ADDR_W-1:0] r_offset;
   logic              r_pend;
   logic [ADDR_W-1:0] w_sum;
   logic              w_clear;
   logic              w_pend_nxt;

   assign w_sum  = r_offset + STEP;
   assign o_wrap = i_advance && (w_sum == FRAME);

   // Decide whether a sync clear takes effect this cycle and what the offset becomes.
   always_comb begin
      w_clear      = 1'b0;
      o_offset_nxt = r_offset;
      w_pend_nxt   = r_pend;
      if (i_busy) begin
         if (i_advance) begin
            w_clear    = r_pend || i_sync_rise;
            w_pend_nxt = 1'b0;
         end else if (i_sync_rise) begin
            w_pend_nxt = 1'b1;
         end
      end else begin
         w_clear = i_sync_rise;
      end
      if (w_clear || o_wrap) begin
         o_offset_nxt = '0;
      end else if (i_advance) begin
         o_offset_nxt = w_sum;
      end
   end

   // Offset and pending-sync registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_offset <= '0;
         r_pend   <= 1'b0;
      end else begin
         r_offset <= o_offset_nxt;
         r_pend   <= w_pend_nxt;
      end
   end

`ifdef SDRAM_PING_PONG_EN
   logic r_bank;

   // Write side toggles its bank per frame; read side follows the opposite of the writer.
   always_comb begin
      o_bank_nxt = r_bank;
      if (BANK_LOAD) begin
         if (o_wrap || w_clear) begin
            o_bank_nxt = i_bank_load;
         end
      end else if (o_wrap) begin
         o_bank_nxt = ~r_bank;
      end
   end

   // Bank bit register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_bank <= 1'b0;
      end else begin
         r_bank <= o_bank_nxt;
      end
   end
`endif

endmodule

// File: rtl/sdram_burst_sched.sv
// Burst scheduler between the FIFO trigger logic and the SDRAM command engine.
// Arbitrates write/read burst requests, strobes the FIFOs during data beats and
// keeps the linear frame write/read addresses.
// Define SDRAM_PING_PONG_EN for two alternating frame buffers.
module sdram_burst_sched
   import sdram_pkg::*;
#(
   parameter int BURST_LEN   = BURST_LEN_DEF,
   parameter int FRAME_WORDS = FRAME_WORDS_DEF,
   parameter int ADDR_W      = ADDR_W_DEF
) (
   input  logic              sclk,
   input  logic              s_rst,
   input  logic              wr_trig,
   input  logic              rd_trig,
   input  logic              wr_vsync,
   input  logic              rd_vsync,
   output logic              cmd_req,
   output logic              cmd_wr,
   output logic [ADDR_W-1:0] cmd_addr,
   input  logic              cmd_ack,
   input  logic              data_beat,
   input  logic              cmd_done,
   output logic              wfifo_rd_en,
   output logic              rfifo_wr_en,
   output logic              flag_wr_end
);

   localparam int CNT_W = $clog2(BURST_LEN) + 1;
   localparam logic [CNT_W-1:0] BEAT_MAX = CNT_W'(BURST_LEN);

   sched_state_e      r_state;
   sched_state_e      w_next_state;
   logic              r_last_wr;
   logic [CNT_W-1:0]  r_beat_cnt;
   logic              r_wr_vs_d;
   logic              r_rd_vs_d;
   logic              r_flag_wr_end;
   logic              r_cmd_req;
   logic              r_cmd_wr;
   logic [ADDR_W-1:0] r_cmd_addr;

   logic              w_wr_el;
   logic              w_rd_el;
   logic              w_in_data;
   logic              w_beat_live;
   logic              w_wr_busy;
   logic              w_rd_busy;
   logic              w_wr_adv;
   logic              w_rd_adv;
   logic              w_wr_wrap;
   logic              w_rd_wrap;
   logic [ADDR_W-1:0] w_wr_off_nxt;
   logic [ADDR_W-1:0] w_rd_off_nxt;
   logic [ADDR_W-1:0] w_wr_addr_nxt;
   logic [ADDR_W-1:0] w_rd_addr_nxt;

   assign w_wr_el     = wr_trig;
   assign w_rd_el     = rd_trig && r_flag_wr_end;
   assign w_in_data   = (r_state == WR_DATA) || (r_state == RD_DATA);
   assign w_beat_live = data_beat && (r_beat_cnt != BEAT_MAX);
   assign w_wr_busy   = (r_state == WR_REQ) || (r_state == WR_DATA);
   assign w_rd_busy   = (r_state == RD_REQ) || (r_state == RD_DATA);
   assign w_wr_adv    = (r_state == WR_DATA) && cmd_done;
   assign w_rd_adv    = (r_state == RD_DATA) && cmd_done;

   assign wfifo_rd_en = (r_state == WR_DATA) && w_beat_live;
   assign rfifo_wr_en = (r_state == RD_DATA) && w_beat_live;
   assign cmd_req     = r_cmd_req;
   assign cmd_wr      = r_cmd_wr;
   assign cmd_addr    = r_cmd_addr;
   assign flag_wr_end = r_flag_wr_end;

`ifdef SDRAM_PING_PONG_EN
   localparam logic [ADDR_W-1:0] FRAME_BASE = ADDR_W'(FRAME_WORDS);
   logic w_wr_bank_nxt;
   logic w_rd_bank_nxt;
   logic r_wr_bank;

   // Current write bank, used to steer the reader to the finished buffer.
   always_ff @(posedge sclk) begin
      if (s_rst) begin
         r_wr_bank <= 1'b0;
      end else begin
         r_wr_bank <= w_wr_bank_nxt;
      end
   end

   assign w_wr_addr_nxt = w_wr_bank_nxt ? (FRAME_BASE + w_wr_off_nxt) : w_wr_off_nxt;
   assign w_rd_addr_nxt = w_rd_bank_nxt ? (FRAME_BASE + w_rd_off_nxt) : w_rd_off_nxt;
`else
   assign w_wr_addr_nxt = w_wr_off_nxt;
   assign w_rd_addr_nxt = w_rd_off_nxt;
`endif

   frame_addr_cnt #(
      .ADDR_W      (ADDR_W),
      .BURST_LEN   (BURST_LEN),
      .FRAME_WORDS (FRAME_WORDS)
`ifdef SDRAM_PING_PONG_EN
      ,
      .BANK_LOAD   (1'b0)
`endif
   ) u_wr_addr (
      .i_clk        (sclk),
      .i_rst        (s_rst),
      .i_busy       (w_wr_busy),
      .i_advance    (w_wr_adv),
      .i_sync_rise  (wr_vsync && !r_wr_vs_d),
`ifdef SDRAM_PING_PONG_EN
      .i_bank_load  (1'b0),
      .o_bank_nxt   (w_wr_bank_nxt),
`endif
      .o_offset_nxt (w_wr_off_nxt),
      .o_wrap       (w_wr_wrap)
   );

   frame_addr_cnt #(
      .ADDR_W      (ADDR_W),
      .BURST_LEN   (BURST_LEN),
      .FRAME_WORDS (FRAME_WORDS)
`ifdef SDRAM_PING_PONG_EN
      ,
      .BANK_LOAD   (1'b1)
`endif
   ) u_rd_addr (
      .i_clk        (sclk),
      .i_rst        (s_rst),
      .i_busy       (w_rd_busy),
      .i_advance    (w_rd_adv),
      .i_sync_rise  (rd_vsync && !r_rd_vs_d),
`ifdef SDRAM_PING_PONG_EN
      .i_bank_load  (~r_wr_bank),
      .o_bank_nxt   (w_rd_bank_nxt),
`endif
      .o_offset_nxt (w_rd_off_nxt),
      .o_wrap       (w_rd_wrap)
   );

   // State register plus vsync edge history, round-robin memory and the frame-done flag.
   always_ff @(posedge sclk) begin
      if (s_rst) begin
         r_state       <= IDLE;
         r_wr_vs_d     <= 1'b0;
         r_rd_vs_d     <= 1'b0;
         r_last_wr     <= 1'b0;
         r_flag_wr_end <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_wr_vs_d <= wr_vsync;
         r_rd_vs_d <= rd_vsync;
         if (w_wr_adv) begin
            r_last_wr <= 1'b1;
         end else if (w_rd_adv) begin
            r_last_wr <= 1'b0;
         end
         if (w_wr_wrap) begin
            r_flag_wr_end <= 1'b1;
         end
      end
   end

   // Next-state logic: round-robin arbitration in IDLE, handshakes elsewhere.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_wr_el && w_rd_el) begin
               w_next_state = r_last_wr ? RD_REQ : WR_REQ;
            end else if (w_wr_el) begin
               w_next_state = WR_REQ;
            end else if (w_rd_el) begin
               w_next_state = RD_REQ;
            end
         end
         WR_REQ:  if (cmd_ack)  w_next_state = WR_DATA;
         WR_DATA: if (cmd_done) w_next_state = IDLE;
         RD_REQ:  if (cmd_ack)  w_next_state = RD_DATA;
         RD_DATA: if (cmd_done) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Beat counter saturates at one burst so excess beats never strobe a FIFO.
   always_ff @(posedge sclk) begin
      if (s_rst) begin
         r_beat_cnt <= '0;
      end else if (w_in_data && !cmd_done) begin
         if (w_beat_live) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
         end
      end else begin
         r_beat_cnt <= '0;
      end
   end

   // Registered command outputs, loaded with the address the counters hold after this edge.
   always_ff @(posedge sclk) begin
      if (s_rst) begin
         r_cmd_req  <= 1'b0;
         r_cmd_wr   <= 1'b0;
         r_cmd_addr <= '0;
      end else begin
         r_cmd_req <= (w_next_state == WR_REQ) || (w_next_state == RD_REQ);
         if (w_next_state == WR_REQ) begin
            r_cmd_wr   <= 1'b1;
            r_cmd_addr <= w_wr_addr_nxt;
         end else if (w_next_state == RD_REQ) begin
            r_cmd_wr   <= 1'b0;
            r_cmd_addr <= w_rd_addr_nxt;
         end
      end
   end

   // The read-side wrap pulse only matters for bank steering inside the read counter.
   logic w_rd_wrap_seen;
   assign w_rd_wrap_seen = w_rd_wrap;

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Directed self-checking bench for sdram_burst_sched, scaled down to
// 16-word bursts and 64-word frames so whole frames fit in a short run.
module tb_sdram_burst_sched;

   localparam int BL = 16;
   localparam int FW = 64;
   localparam int AW = 8;
`ifdef SDRAM_PING_PONG_EN
   localparam int WB = FW;
`else
   localparam int WB = 0;
`endif

   logic          sclk = 1'b0;
   logic          s_rst = 1'b1;
   logic          wr_trig = 1'b0;
   logic          rd_trig = 1'b0;
   logic          wr_vsync = 1'b0;
   logic          rd_vsync = 1'b0;
   logic          cmd_ack = 1'b0;
   logic          data_beat = 1'b0;
   logic          cmd_done = 1'b0;
   logic          cmd_req;
   logic          cmd_wr;
   logic [AW-1:0] cmd_addr;
   logic          wfifo_rd_en;
   logic          rfifo_wr_en;
   logic          flag_wr_end;

   int checks = 0;
   int failures = 0;

   logic          bWr;
   logic [AW-1:0] bAddr;
   int            wCnt;
   int            rCnt;

   sdram_burst_sched #(
      .BURST_LEN   (BL),
      .FRAME_WORDS (FW),
      .ADDR_W      (AW)
   ) dut (
      .sclk        (sclk),
      .s_rst       (s_rst),
      .wr_trig     (wr_trig),
      .rd_trig     (rd_trig),
      .wr_vsync    (wr_vsync),
      .rd_vsync    (rd_vsync),
      .cmd_req     (cmd_req),
      .cmd_wr      (cmd_wr),
      .cmd_addr    (cmd_addr),
      .cmd_ack     (cmd_ack),
      .data_beat   (data_beat),
      .cmd_done    (cmd_done),
      .wfifo_rd_en (wfifo_rd_en),
      .rfifo_wr_en (rfifo_wr_en),
      .flag_wr_end (flag_wr_end)
   );

   always #5 sclk = ~sclk;

   task automatic stepClock;
      @(posedge sclk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // One full burst: wait for a request, acknowledge after ackDelay cycles,
   // drive the given number of beats (optional rd_vsync rise at syncBeat), then done.
   task automatic applyStimulus(input int ackDelay, input int beats, input int syncBeat,
                                output logic wr, output logic [AW-1:0] addr,
                                output int wc, output int rc);
      int n = 0;
      wc = 0;
      rc = 0;
      while (!cmd_req && n < 50) begin
         stepClock();
         n++;
      end
      checkOutput("req_seen", cmd_req, 1);
      wr = cmd_wr;
      addr = cmd_addr;
      repeat (ackDelay) stepClock();
      cmd_ack = 1'b1;
      stepClock();
      cmd_ack = 1'b0;
      checkOutput("req_drop", cmd_req, 0);
      for (int i = 0; i < beats; i++) begin
         data_beat = 1'b1;
         if (i == syncBeat) rd_vsync = 1'b1;
         #1;
         wc += int'(wfifo_rd_en);
         rc += int'(rfifo_wr_en);
         stepClock();
      end
      data_beat = 1'b0;
      rd_vsync = 1'b0;
      cmd_done = 1'b1;
      stepClock();
      cmd_done = 1'b0;
      checkOutput("req_after_done", cmd_req, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      // Reset state
      repeat (3) stepClock();
      checkOutput("rst_cmd_req", cmd_req, 0);
      checkOutput("rst_cmd_wr", cmd_wr, 0);
      checkOutput("rst_cmd_addr", cmd_addr, 0);
      checkOutput("rst_wfifo", wfifo_rd_en, 0);
      checkOutput("rst_rfifo", rfifo_wr_en, 0);
      checkOutput("rst_flag", flag_wr_end, 0);
      s_rst = 1'b0;

      // Read not eligible before the first frame is stored
      rd_trig = 1'b1;
      repeat (5) stepClock();
      checkOutput("rd_blocked", cmd_req, 0);
      rd_trig = 1'b0;

      // First write: request one cycle after the trigger is sampled
      wr_trig = 1'b1;
      stepClock();
      checkOutput("req_latency", cmd_req, 1);
      applyStimulus(2, BL, -1, bWr, bAddr, wCnt, rCnt);
      checkOutput("w0_wr", bWr, 1);
      checkOutput("w0_addr", bAddr, 0);
      checkOutput("w0_wstrobes", wCnt, BL);
      checkOutput("w0_rstrobes", rCnt, 0);

      // Excess beats do not strobe the write FIFO
      applyStimulus(0, BL + 4, -1, bWr, bAddr, wCnt, rCnt);
      checkOutput("w1_addr", bAddr, BL);
      checkOutput("w1_sat_strobes", wCnt, BL);

      applyStimulus(1, BL, -1, bWr, bAddr, wCnt, rCnt);
      checkOutput("w2_addr", bAddr, 2 * BL);
      checkOutput("flag_mid_frame", flag_wr_end, 0);
      applyStimulus(1, BL, -1, bWr, bAddr, wCnt, rCnt);
      checkOutput("w3_addr", bAddr, 3 * BL);
      checkOutput("flag_frame_done", flag_wr_end, 1);

      // Both triggers high: reads and writes alternate, read first
      rd_trig = 1'b1;
      applyStimulus(1, BL, -1, bWr, bAddr, wCnt, rCnt);
      checkOutput("rr0_wr", bWr, 0);
      checkOutput("rr0_addr", bAddr, 0);
      checkOutput("rr0_rstrobes", rCnt, BL);
      checkOutput("rr0_wstrobes", wCnt, 0);
      applyStimulus(1, BL, -1, bWr, bAddr, wCnt, rCnt);
      checkOutput("rr1_wr", bWr, 1);
      checkOutput("rr1_addr", bAddr, WB + 0);
      applyStimulus(1, BL, -1, bWr, bAddr, wCnt, rCnt);
      checkOutput("rr2_wr", bWr, 0);
      checkOutput("rr2_addr", bAddr, BL);
      applyStimulus(1, BL, -1, bWr, bAddr, wCnt, rCnt);
      checkOutput("rr3_wr", bWr, 1);
      checkOutput("rr3_addr", bAddr, WB + BL);

      // rd_vsync rise mid-read: the read address clears at burst end
      wr_trig = 1'b0;
      applyStimulus(1, BL, 5, bWr, bAddr, wCnt, rCnt);
      checkOutput("vs_rd_wr", bWr, 0);
      checkOutput("vs_rd_addr", bAddr, 2 * BL);
      applyStimulus(1, BL, -1, bWr, bAddr, wCnt, rCnt);
      rd_trig = 1'b0;
      checkOutput("vs_next_rd_addr", bAddr, 0);

      // wr_vsync rise while idle clears the write address
      stepClock();
      wr_vsync = 1'b1;
      stepClock();
      wr_vsync = 1'b0;
      stepClock();
      wr_trig = 1'b1;
      applyStimulus(1, BL, -1, bWr, bAddr, wCnt, rCnt);
      checkOutput("vs_wr_wr", bWr, 1);
      checkOutput("vs_wr_addr", bAddr, WB + 0);

      // Reset in the middle of a write burst
      while (!cmd_req) stepClock();
      cmd_ack = 1'b1;
      stepClock();
      cmd_ack = 1'b0;
      data_beat = 1'b1;
      repeat (3) stepClock();
      s_rst = 1'b1;
      data_beat = 1'b0;
      stepClock();
      checkOutput("midrst_req", cmd_req, 0);
      checkOutput("midrst_flag", flag_wr_end, 0);
      checkOutput("midrst_addr", cmd_addr, 0);
      s_rst = 1'b0;
      applyStimulus(1, BL, -1, bWr, bAddr, wCnt, rCnt);
      wr_trig = 1'b0;
      checkOutput("postrst_wr", bWr, 1);
      checkOutput("postrst_addr", bAddr, 0);
      checkOutput("postrst_wstrobes", wCnt, BL);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
